// File: rtl/dlx_instr_encoder_if.sv
// Request bundle between a program source (test bench or boot sequencer)
// and the DLX instruction encoder. The master drives field-level requests;
// the slave answers with req_ready.
interface dlx_instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_fmt;
  logic [5:0]  req_op;
  logic [5:0]  req_func;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [4:0]  req_rd;
  logic [25:0] req_imm;

  modport master (
    output req_valid, req_fmt, req_op, req_func, req_rs1, req_rs2, req_rd, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_fmt, req_op, req_func, req_rs1, req_rs2, req_rd, req_imm,
    output req_ready
  );
endinterface

// File: rtl/dlx_instr_encoder.sv
// DLX program loader: packs field-level instruction requests into 32-bit
// words, streams them to consecutive word addresses of instruction memory
// and appends drain NOPs once the program is finished.
module dlx_instr_encoder #(
  parameter int AW        = 16,
  parameter int MAX_WORDS = 256,
  parameter int PAD_NOPS  = 4,
  parameter int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  dlx_instr_encoder_if.slave    req,
  input  logic                  finish,
  output logic                  imem_we,
  output logic [AW-1:0]         imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CW-1:0]         word_count
);

  localparam int PW = $clog2(PAD_NOPS + 1);

  localparam logic [31:0]   NOP_WORD  = 32'h0000_0015;
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_WORDS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PAD_CNT   = PW'(PAD_NOPS);
  localparam logic [PW-1:0] PAD_ONE   = PW'(1);
  localparam logic [AW-1:0] WORD_STEP = AW'(4);

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_J   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PAD  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // I-type opcodes 0/1 collide with the R/special space; J-type only
  // allows J and JAL.
  function automatic logic is_illegal(input logic [1:0] fmt, input logic [5:0] op);
    logic ill;
    case (fmt)
      FMT_I:   ill = (op[5:1] == 5'b00000);
      FMT_J:   ill = !((op == 6'b000010) || (op == 6'b000011));
      default: ill = 1'b0;
    endcase
    return ill;
  endfunction

  // Bit packing expected by the ID-stage control decoder; illegal
  // requests collapse to a NOP so the pipeline never sees them.
  function automatic logic [31:0] encode(
    input logic [1:0]  fmt,
    input logic [5:0]  op,
    input logic [5:0]  func,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic [25:0] imm
  );
    logic [31:0] w;
    case (fmt)
      FMT_R:   w = {6'b000000, rs1, rs2, rd, 5'b00000, func};
      FMT_I:   w = {op, rs1, rd, imm[15:0]};
      FMT_J:   w = {op, imm};
      default: w = NOP_WORD;
    endcase
    if (is_illegal(fmt, op)) begin
      w = NOP_WORD;
    end else begin
      w = w;
    end
    return w;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   pad_q, pad_d;
  logic [AW-1:0]   next_addr_q, next_addr_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            req_ready_s;
  logic            handshake_s;
  logic [AW-1:0]   base_aligned_s;
  logic            base_lo_unused_s;

  // Word alignment: the two low address bits carry no information.
  assign base_aligned_s   = {base_addr[AW-1:2], 2'b00};
  assign base_lo_unused_s = ^base_addr[1:0];

  // count_q already includes the word registered for the current write,
  // so no separate pending term is needed in the capacity check.
  assign req_ready_s = (state_q == ST_RUN) && (count_q < MAX_CNT) && !start;
  assign handshake_s = req.req_valid && req_ready_s;
  assign req.req_ready = req_ready_s;

  // Next-state, write-port and status computation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pad_d       = pad_q;
    next_addr_d = next_addr_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;

    if (start) begin
      // Restart wins over everything, including a finish in the same cycle.
      state_d     = ST_RUN;
      count_d     = '0;
      pad_d       = '0;
      next_addr_d = base_aligned_s;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (handshake_s) begin
            we_d        = 1'b1;
            addr_d      = next_addr_q;
            wdata_d     = encode(req.req_fmt, req.req_op, req.req_func,
                                 req.req_rs1, req.req_rs2, req.req_rd, req.req_imm);
            next_addr_d = next_addr_q + WORD_STEP;
            count_d     = count_q + CNT_ONE;
            err_d       = err_q | is_illegal(req.req_fmt, req.req_op);
          end else begin
            we_d = 1'b0;
          end
          if (finish) begin
            state_d = ST_PAD;
            pad_d   = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAD: begin
          if ((pad_q == PAD_CNT) || (count_q == MAX_CNT)) begin
            state_d = ST_DONE;
          end else begin
            we_d        = 1'b1;
            addr_d      = next_addr_q;
            wdata_d     = NOP_WORD;
            next_addr_d = next_addr_q + WORD_STEP;
            count_d     = count_q + CNT_ONE;
            pad_d       = pad_q + PAD_ONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAD);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs; reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      pad_q       <= '0;
      next_addr_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pad_q       <= pad_d;
      next_addr_q <= next_addr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = count_q;

endmodule
